button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Converts the debounced push-button levels into single-cycle event pulses, with optional hold-to-repeat, and derives the processor clock-enable for run/single-step execution on the board. Sits directly downstream of the button debouncer and upstream of the single-cycle RISC-V core's clock-enable input. One clock domain, no asynchronous inputs: `btn_db` is already debounced and synchronous to `clk`.

## Interface
- `N_BTN`, 5: number of button channels.
- `HOLD_DELAY`, 50_000_000: cycles from the press pulse to the first repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, 10_000_000: cycles between successive repeat pulses; must be ≥2.
- `STEP_BTN`, 0: channel index that single-steps the core.
- `MODE_BTN`, 1: channel index that toggles run/step mode; must differ from `STEP_BTN`.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_db` in N_BTN: debounced button levels, 1 = pressed.
- `btn_evt` out N_BTN: one-cycle pulse per press and per repeat.
- `btn_held` out N_BTN: level, high while the channel is not IDLE.
- `run_mode` out 1: 1 = free run, 0 = single step.
- `cpu_en` out 1: clock enable to the core.

## Operation
- Per channel FSM, states IDLE, WAIT, REPEAT; 32-bit counter `cnt`.
- IDLE: if `btn_db[i]`=1, go to WAIT, `cnt`<=0, `btn_evt[i]`<=1 (press pulse).
- WAIT: if `btn_db[i]`=0, go to IDLE, `cnt`<=0, no pulse. Else if `cnt`==HOLD_DELAY-1, go to REPEAT, `cnt`<=0, pulse. Else `cnt`++.
- REPEAT: if `btn_db[i]`=0, go to IDLE, no pulse. Else if `cnt`==REPEAT_PERIOD-1, `cnt`<=0, pulse. Else `cnt`++.
- Release has priority over terminal count in the same cycle. A release pulse is never generated.
- `btn_held[i]` is high in WAIT and REPEAT.
- `run_mode` toggles only on the press pulse of MODE_BTN (IDLE to WAIT transition). Repeat pulses on MODE_BTN are ignored.
- `cpu_en` = 1 every cycle when `run_mode`=1. Otherwise `cpu_en` = `btn_evt[STEP_BTN]`, so holding step auto-steps at the repeat rate.
- Channels are independent. Simultaneous presses on several channels each produce their own pulse in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `btn_evt`=0, `btn_held`=0, `run_mode`=0, `cpu_en`=0; all FSMs IDLE, `cnt`=0.
- Press latency: `btn_db[i]` sampled 1 at edge k from IDLE gives `btn_evt[i]`=1 and `btn_held[i]`=1 after edge k. `btn_evt[i]` is cleared at edge k+1.
- First repeat pulse: HOLD_DELAY cycles after the press pulse. Subsequent repeats: every REPEAT_PERIOD cycles.
- `run_mode` and `cpu_en` update at the same edge as the originating pulse:
  - Toggle to run: `cpu_en` high from that cycle on.
  - Toggle to step: `cpu_en` low that cycle unless STEP_BTN pulses in the same cycle.
- `rst` asserted mid-hold: returns to IDLE. A button still held after `rst` deasserts produces a fresh press pulse at the first edge with `rst`=0.
- `cnt` never wraps: it is bounded by the terminal compares.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: behaviour exactly as above.
- Not defined:
  - WAIT never transitions to REPEAT; the channel stays in WAIT until release.
  - `cnt` and its compare logic are removed.
  - Exactly one `btn_evt` pulse per press. `btn_held` still behaves as specified.

## Structure
- Shared package `btn_pkg`: channel state encoding (IDLE=2'd0, WAIT=2'd1, REPEAT=2'd2) and the counter width constant (32).
- Sub-module `btn_event_channel`: one FSM plus counter, outputs evt/held, instantiated N_BTN times via generate.
- Top level holds `run_mode` and `cpu_en` only.

## Test plan
All directed tests use HOLD_DELAY=8, REPEAT_PERIOD=3.
- Reset check: `rst` high for 3 cycles with `btn_db`=5'b11111 → all outputs 0. After release, `btn_evt`=5'b11111 for exactly 1 cycle.
- Short press: `btn_db[2]` high 5 cycles → one `btn_evt[2]` pulse 1 cycle after the rise; `btn_held[2]` high 5 cycles; no repeats.
- Hold/repeat: `btn_db[0]` high 20 cycles → pulses at press+0, +8, +11, +14, +17; `cpu_en` mirrors them (step mode). Without the macro: only +0.
- Mode toggle: press MODE_BTN and hold 20 cycles → `run_mode` 0→1 once, `cpu_en` constant 1. Press again → `run_mode`=0, `cpu_en` low.
- Simultaneous events: MODE_BTN and STEP_BTN rise in the same cycle while in run mode → `run_mode`→0, `cpu_en`=1 that cycle (step pulse), then 0.
- Release at terminal count: drop `btn_db[3]` in the cycle where `cnt`==7 in WAIT → no pulse; state IDLE; `btn_held[3]`=0 next cycle.

Source files
------------

// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared definitions for the button event controller:
//                per-channel state encoding and hold counter width.
//  Config      : BTN_AUTOREPEAT_EN (consumed by btn_event_channel)
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Width of the per-channel hold/repeat counter.
    localparam int unsigned CNT_W = 32;

    // Per-channel state encoding.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/btn_event_channel.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_channel
//  Description : One button channel. Emits a single-cycle event on press and,
//                with auto-repeat enabled, further events while held.
//                pulse_o is the combinational value that evt_o takes at the
//                next edge, so the top can act on an event in the same cycle.
//  Config      : BTN_AUTOREPEAT_EN - enables the hold/repeat counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_channel
    import btn_pkg::*;
#(
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o,
    output logic evt_o,
    output logic held_o
);

    btn_state_e state_q;
    logic       evt_q;
    logic       held_q;
    logic       press;

    // Both timing parameters must leave room for at least one counting cycle.
    if (HOLD_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_timing
        $error("btn_event_channel: HOLD_DELAY and REPEAT_PERIOD must be >= 2");
    end

    // A press is a pressed level seen while idle.
    assign press = (state_q == ST_IDLE) && btn_i;

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             term_hit;

    // Terminal count of whichever interval the channel is currently timing.
    assign term_hit = ((state_q == ST_WAIT)   && (cnt_q == HOLD_TERM)) ||
                      ((state_q == ST_REPEAT) && (cnt_q == REPEAT_TERM));

    // Release masks a terminal count falling in the same cycle.
    assign pulse_o = press || (btn_i && term_hit);

    // Channel FSM with hold/repeat counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            evt_q <= pulse_o;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (btn_i) begin
                        state_q <= ST_WAIT;
                        held_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!btn_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == HOLD_TERM) begin
                        state_q <= ST_REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!btn_i) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                    end else if (cnt_q == REPEAT_TERM) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end
`else
    // Without auto-repeat only the press itself produces an event.
    assign pulse_o = press;

    // Channel FSM without counter: WAIT is held until release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            evt_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            evt_q <= pulse_o;
            case (state_q)
                ST_IDLE: begin
                    if (btn_i) begin
                        state_q <= ST_WAIT;
                        held_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!btn_i) begin
                        state_q <= ST_IDLE;
                        held_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end
`endif

    assign evt_o  = evt_q;
    assign held_o = held_q;

endmodule : btn_event_channel
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_ctrl
//  Description : Converts debounced button levels into event pulses (one
//                channel per button) and derives run/step mode and the core
//                clock enable from the MODE and STEP channels.
//  Config      : BTN_AUTOREPEAT_EN - hold-to-repeat on every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_ctrl #(
    parameter int N_BTN         = 5,
    parameter int HOLD_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int STEP_BTN      = 0,
    parameter int MODE_BTN      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_evt,
    output logic [N_BTN-1:0] btn_held,
    output logic             run_mode,
    output logic             cpu_en
);

    // One-hot selector for the step channel.
    localparam logic [N_BTN-1:0] STEP_MASK = N_BTN'(1) << STEP_BTN;

    logic [N_BTN-1:0] ch_pulse;
    logic             step_pulse;
    logic             mode_press;
    logic             run_mode_q, run_mode_d;
    logic             cpu_en_q, cpu_en_d;

    // Step and mode must be two distinct, existing channels.
    if (STEP_BTN == MODE_BTN || STEP_BTN < 0 || STEP_BTN >= N_BTN ||
        MODE_BTN < 0 || MODE_BTN >= N_BTN) begin : g_bad_channels
        $error("button_event_ctrl: STEP_BTN/MODE_BTN invalid");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_event_channel #(
            .HOLD_DELAY    (HOLD_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_db[i]),
            .pulse_o (ch_pulse[i]),
            .evt_o   (btn_evt[i]),
            .held_o  (btn_held[i])
        );
    end

    assign step_pulse = |(ch_pulse & STEP_MASK);
    // Held is low exactly in IDLE, so this is the press transition only;
    // repeat pulses on the mode channel never toggle.
    assign mode_press = btn_db[MODE_BTN] & ~btn_held[MODE_BTN];

    // Next mode and clock enable, aligned with the pulse they come from.
    always_comb begin
        run_mode_d = run_mode_q ^ mode_press;
        cpu_en_d   = run_mode_d | step_pulse;
    end

    // Mode and clock-enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_mode_q <= 1'b0;
            cpu_en_q   <= 1'b0;
        end else begin
            run_mode_q <= run_mode_d;
            cpu_en_q   <= cpu_en_d;
        end
    end

    assign run_mode = run_mode_q;
    assign cpu_en   = cpu_en_q;

endmodule : button_event_ctrl
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_ctrl
//  Description : Scoreboard bench for button_event_ctrl. A reference model
//                tracks how long each button has been held and pushes the
//                expected outputs for every driven cycle; they are popped
//                and compared one clock later.
//  Config      : BTN_AUTOREPEAT_EN - selects repeat expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_ctrl;

    localparam int N_BTN         = 5;
    localparam int HOLD_DELAY    = 8;
    localparam int REPEAT_PERIOD = 3;
    localparam int STEP_BTN      = 0;
    localparam int MODE_BTN      = 1;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR_EN = 1'b1;
`else
    localparam bit AR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_BTN-1:0] btn_db = '0;
    logic [N_BTN-1:0] btn_evt;
    logic [N_BTN-1:0] btn_held;
    logic             run_mode;
    logic             cpu_en;

    typedef struct packed {
        logic [N_BTN-1:0] evt;
        logic [N_BTN-1:0] held;
        logic             run;
        logic             cpu;
    } exp_t;

    exp_t sb_q[$];
    exp_t s_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   total_evt0 = 0;
    int   total_cpu  = 0;

    // Reference model state: held flag and cycles since the press.
    bit   m_held[N_BTN];
    int   m_t[N_BTN];
    bit   m_run;

    button_event_ctrl #(
        .N_BTN         (N_BTN),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .STEP_BTN      (STEP_BTN),
        .MODE_BTN      (MODE_BTN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_db   (btn_db),
        .btn_evt  (btn_evt),
        .btn_held (btn_held),
        .run_mode (run_mode),
        .cpu_en   (cpu_en)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Repeat events fall HOLD_DELAY after the press, then every REPEAT_PERIOD.
    function automatic bit repeat_due(input int t);
        return AR_EN && ((t == HOLD_DELAY) ||
               ((t > HOLD_DELAY) && (((t - HOLD_DELAY) % REPEAT_PERIOD) == 0)));
    endfunction

    function automatic exp_t model_step(input logic [N_BTN-1:0] b, input logic r);
        exp_t e;
        e = '0;
        if (r) begin
            for (int i = 0; i < N_BTN; i++) begin
                m_held[i] = 1'b0;
                m_t[i]    = 0;
            end
            m_run = 1'b0;
            return e;
        end
        for (int i = 0; i < N_BTN; i++) begin
            if (b[i]) begin
                if (!m_held[i]) begin
                    m_t[i]   = 0;
                    e.evt[i] = 1'b1;
                    if (i == MODE_BTN) m_run = ~m_run;
                end else begin
                    m_t[i]++;
                    e.evt[i] = repeat_due(m_t[i]);
                end
                m_held[i] = 1'b1;
                e.held[i] = 1'b1;
            end else begin
                m_held[i] = 1'b0;
                m_t[i]    = 0;
            end
        end
        e.run = m_run;
        e.cpu = m_run | e.evt[STEP_BTN];
        return e;
    endfunction

    // Apply one cycle of stimulus and queue its expected outputs.
    task automatic drive(input logic [N_BTN-1:0] b, input logic r);
        btn_db = b;
        rst    = r;
        sb_q.push_back(model_step(b, r));
        @(negedge clk);
    endtask

    // Compare each queued expectation just after the edge that produces it.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            s_exp = sb_q.pop_front();
            check_val("btn_evt",  32'(btn_evt),  32'(s_exp.evt));
            check_val("btn_held", 32'(btn_held), 32'(s_exp.held));
            check_val("run_mode", 32'(run_mode), 32'(s_exp.run));
            check_val("cpu_en",   32'(cpu_en),   32'(s_exp.cpu));
        end
        if (btn_evt[0] === 1'b1) total_evt0++;
        if (cpu_en === 1'b1)     total_cpu++;
    end

    initial begin
        int               s_evt;
        int               s_cpu;
        int               n_rep;
        logic [N_BTN-1:0] rb;
        n_rep = AR_EN ? 5 : 1;
        @(negedge clk);

        // Reset with all buttons down, then a fresh press on every channel.
        repeat (3) drive(5'b11111, 1'b1);
        drive(5'b11111, 1'b0);
        check_val("rst_release_evt", 32'(btn_evt), 32'h1f);
        drive(5'b11111, 1'b0);
        check_val("rst_evt_one_cycle", 32'(btn_evt), 32'h0);
        drive(5'b00000, 1'b0);
        repeat (2) drive(5'b00000, 1'b1);
        drive(5'b00000, 1'b0);

        // Short press on channel 2.
        repeat (5) drive(5'b00100, 1'b0);
        repeat (3) drive(5'b00000, 1'b0);

        // Long hold of the step button in step mode.
        s_evt = total_evt0;
        s_cpu = total_cpu;
        repeat (20) drive(5'b00001, 1'b0);
        repeat (3) drive(5'b00000, 1'b0);
        check_val("hold_evt0_count", 32'(total_evt0 - s_evt), 32'(n_rep));
        check_val("hold_cpu_count",  32'(total_cpu - s_cpu),  32'(n_rep));

        // Hold the mode button: one toggle to run, enable stays high.
        s_cpu = total_cpu;
        repeat (20) drive(5'b00010, 1'b0);
        check_val("mode_cpu_count", 32'(total_cpu - s_cpu), 32'd20);
        check_val("mode_run_on", 32'(run_mode), 32'd1);
        repeat (2) drive(5'b00000, 1'b0);
        drive(5'b00010, 1'b0);
        check_val("mode_run_off", 32'(run_mode), 32'd0);
        check_val("mode_cpu_off", 32'(cpu_en), 32'd0);
        repeat (3) drive(5'b00000, 1'b0);

        // Mode and step together while running.
        drive(5'b00010, 1'b0);
        repeat (2) drive(5'b00000, 1'b0);
        drive(5'b00011, 1'b0);
        check_val("simul_run", 32'(run_mode), 32'd0);
        check_val("simul_cpu", 32'(cpu_en), 32'd1);
        drive(5'b00000, 1'b0);
        check_val("simul_cpu_after", 32'(cpu_en), 32'd0);
        drive(5'b00000, 1'b0);

        // Release exactly on the hold terminal count.
        repeat (8) drive(5'b01000, 1'b0);
        drive(5'b00000, 1'b0);
        check_val("tc_release_held", 32'(btn_held[3]), 32'd0);
        check_val("tc_release_evt",  32'(btn_evt[3]),  32'd0);
        drive(5'b00000, 1'b0);

        // Reset in the middle of a hold, button kept down.
        repeat (5) drive(5'b10000, 1'b0);
        drive(5'b10000, 1'b1);
        check_val("midrst_held", 32'(btn_held[4]), 32'd0);
        drive(5'b10000, 1'b0);
        check_val("midrst_repress", 32'(btn_evt[4]), 32'd1);
        repeat (3) drive(5'b10000, 1'b0);
        drive(5'b00000, 1'b0);

        // Slowly changing random buttons with occasional reset.
        rb = '0;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N_BTN; i++)
                if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
            drive(rb, ($urandom_range(0, 63) == 0));
        end
        repeat (2) drive(5'b00000, 1'b0);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_button_event_ctrl
`default_nettype wire
